// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit holding the architectural HI/LO registers.
// 33 cycles per operation; busy holds off new starts, done pulses once HI/LO are written.
module muldiv_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        hi_we,
    input  logic        lo_we,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

    state_t      r_state, w_state_nxt;
    logic        r_is_div, r_sign_a, r_neg;
    logic [31:0] r_a, r_mag_b, r_quo, r_hi, r_lo;
    logic [4:0]  r_cnt;
    logic [63:0] r_prod;
    logic [32:0] r_rem;
    logic        r_busy, r_done;

    // Unsigned ops (op[0]=1) never treat the top bit as a sign.
    logic        w_sa, w_sb;
    logic [31:0] w_mag_a, w_mag_b;
    assign w_sa    = ~op[0] & a[31];
    assign w_sb    = ~op[0] & b[31];
    assign w_mag_a = w_sa ? -a : a;
    assign w_mag_b = w_sb ? -b : b;

    logic [32:0] w_add, w_rem_sh;
    logic [33:0] w_diff;
    logic [63:0] w_prod_fix;
    logic [31:0] w_quo_fix, w_rem_fix;
    assign w_add      = {1'b0, r_prod[63:32]} + {1'b0, r_mag_b};
    assign w_rem_sh   = {r_rem[31:0], r_quo[31]};
    assign w_diff     = {1'b0, w_rem_sh} - {2'b00, r_mag_b};
    assign w_prod_fix = r_neg ? -r_prod : r_prod;
    assign w_quo_fix  = r_neg ? -r_quo : r_quo;
    assign w_rem_fix  = r_sign_a ? -r_rem[31:0] : r_rem[31:0];

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_CALC;
            S_CALC:  if (r_cnt == 5'd31) w_state_nxt = S_FIX;
            S_FIX:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_is_div <= 1'b0;
            r_sign_a <= 1'b0;
            r_neg    <= 1'b0;
            r_a      <= '0;
            r_mag_b  <= '0;
            r_quo    <= '0;
            r_rem    <= '0;
            r_prod   <= '0;
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != S_IDLE);
            r_done  <= (r_state == S_FIX);
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_is_div <= op[1];
                        r_sign_a <= w_sa;
                        r_neg    <= w_sa ^ w_sb;
                        r_a      <= a;
                        r_mag_b  <= w_mag_b;
                        r_cnt    <= '0;
                        r_prod   <= {32'd0, w_mag_a};
                        r_rem    <= '0;
                        r_quo    <= w_mag_a;
                    end else begin
                        if (hi_we) r_hi <= a;
                        if (lo_we) r_lo <= a;
                    end
                end
                S_CALC: begin
                    r_cnt <= r_cnt + 5'd1;
                    if (!r_is_div) begin
                        // Multiplier sits in the low half and shifts out as the product grows.
                        r_prod <= r_prod[0] ? {w_add, r_prod[31:1]} : {1'b0, r_prod[63:1]};
                    end else if (!w_diff[33]) begin
                        r_rem <= w_diff[32:0];
                        r_quo <= {r_quo[30:0], 1'b1};
                    end else begin
                        r_rem <= w_rem_sh;
                        r_quo <= {r_quo[30:0], 1'b0};
                    end
                end
                S_FIX: begin
                    if (!r_is_div) begin
                        r_hi <= w_prod_fix[63:32];
                        r_lo <= w_prod_fix[31:0];
                    end else if (r_mag_b == 32'd0) begin
                        r_hi <= r_a;
                        r_lo <= 32'hFFFF_FFFF;
                    end else begin
                        r_hi <= w_rem_fix;
                        r_lo <= w_quo_fix;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed plus randomized checks of muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        hi_we = 1'b0;
    logic        lo_we = 1'b0;
    logic        busy, done;
    logic [31:0] hi, lo;

    int n_tests = 0;
    int n_fail  = 0;

    muldiv_unit dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .hi_we(hi_we), .lo_we(lo_we), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // {HI, LO} as the MIPS ISA defines them, computed with plain 64-bit arithmetic.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, q, r;
        logic [63:0] res;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            2'd0: res = sx * sy;
            2'd1: res = {32'd0, x} * {32'd0, y};
            2'd2: begin
                if (y == 32'd0) res = {x, 32'hFFFF_FFFF};
                else begin
                    q = sx / sy;
                    r = sx % sy;
                    res = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (y == 32'd0) res = {x, 32'hFFFF_FFFF};
                else res = {x % y, x / y};
            end
        endcase
        return res;
    endfunction

    task automatic mtx(input bit h, input bit l, input logic [31:0] v);
        logic [31:0] eh, el;
        eh = h ? v : hi;
        el = l ? v : lo;
        @(negedge clk);
        hi_we = h; lo_we = l; a = v;
        @(posedge clk); #1;
        hi_we = 1'b0; lo_we = 1'b0;
        chk("mt_hi", hi, eh);
        chk("mt_lo", lo, el);
        chk("mt_busy_done", {busy, done}, 2'b00);
    endtask

    task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input bit hazard, input bit with_lo);
        logic [63:0] e;
        logic [31:0] old_hi, old_lo;
        int n;
        e = model(o, x, y);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y; lo_we = with_lo;
        old_hi = hi; old_lo = lo;
        @(posedge clk); #1;
        start = 1'b0; lo_we = 1'b0;
        chk("busy_on_accept", busy, 1'b1);
        if (hazard) begin
            a = $urandom;
            b = $urandom;
        end
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            if (hazard && n == 5) begin
                start = 1'b1; hi_we = 1'b1; op = 2'($urandom);
            end else begin
                start = 1'b0; hi_we = 1'b0;
            end
            @(posedge clk); #1;
            n++;
            if (n == 10) chk("hilo_hold_midop", {hi, lo}, {old_hi, old_lo});
        end
        start = 1'b0; hi_we = 1'b0;
        chk("latency", n, 33);
        chk("result", {hi, lo}, e);
        chk("busy_at_done", busy, 1'b0);
        @(posedge clk); #1;
        chk("done_one_cycle", done, 1'b0);
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] rx, ry;
        int seen;
        #1 reset = 1'b1;
        #12 reset = 1'b0;
        #1;
        chk("reset_state", {busy, done, hi, lo}, 66'd0);

        mtx(1'b0, 1'b1, 32'hA5A5_0F0F);
        mtx(1'b1, 1'b0, 32'h5555_AAAA);

        @(posedge clk); #3 reset = 1'b1;
        #1 chk("async_reset", {busy, done, hi, lo}, 66'd0);
        @(negedge clk) reset = 1'b0;

        mtx(1'b1, 1'b0, 32'h1234_5678);
        mtx(1'b1, 1'b1, 32'hCAFE_F00D);

        do_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        chk("multu_max", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        do_op(2'd0, 32'hFFFF_FFFD, 32'd5, 1'b0, 1'b0);
        chk("mult_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
        do_op(2'd0, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
        chk("mult_minmin", {hi, lo}, 64'h4000_0000_0000_0000);
        do_op(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        chk("div_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        do_op(2'd3, 32'd100, 32'd7, 1'b1, 1'b0);
        chk("divu_hazard", {hi, lo}, {32'd2, 32'd14});
        do_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        chk("div_overflow", {hi, lo}, 64'h0000_0000_8000_0000);
        do_op(2'd3, 32'd100, 32'd0, 1'b0, 1'b0);
        chk("divu_by_zero", {hi, lo}, {32'h0000_0064, 32'hFFFF_FFFF});
        do_op(2'd0, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b1);
        chk("start_beats_lowe", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF2);

        // Abort a DIVU partway through with an asynchronous reset.
        @(negedge clk);
        start = 1'b1; op = 2'd3; a = 32'd1000; b = 32'd3;
        @(posedge clk); #1 start = 1'b0;
        repeat (9) @(posedge clk);
        #3 reset = 1'b1;
        #1 chk("abort_reset", {busy, done, hi, lo}, 66'd0);
        @(negedge clk) reset = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        chk("no_activity_after_abort", seen, 0);
        chk("hilo_zero_after_abort", {hi, lo}, 64'd0);
        do_op(2'd1, 32'd3, 32'd4, 1'b0, 1'b0);
        chk("multu_3x4", {hi, lo}, {32'd0, 32'd12});

        for (int i = 0; i < 16; i++) begin
            ro = 2'($urandom_range(0, 3));
            rx = $urandom;
            case ($urandom_range(0, 3))
                0:       ry = 32'd0;
                1:       ry = 32'($urandom_range(1, 20));
                default: ry = $urandom;
            endcase
            do_op(ro, rx, ry, 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit with architectural HI/LO registers for the single-cycle MIPS datapath. It sits directly downstream of the register file: it consumes the two register read ports (rs, rt) for MULT/MULTU/DIV/DIVU/MTHI/MTLO, and its HI/LO outputs feed the write-data mux back into the register file for MFHI/MFLO. Operations take 33 cycles; `busy` stalls the PC while a computation is in flight.

## Interface
Parameters:
- (none)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  launch operation `op` on `a`, `b`; accepted only when busy=0
- op  in  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU
- a  in  32  rs operand (register file Read_data1); also MTHI/MTLO write data
- b  in  32  rt operand (register file Read_data2)
- hi_we  in  1  MTHI: HI <= a
- lo_we  in  1  MTLO: LO <= a
- busy  out  1  registered; high while state != IDLE
- done  out  1  registered one-cycle pulse after HI/LO are updated
- hi  out  32  HI register
- lo  out  32  LO register

## Operation
- States: IDLE, CALC, FIX.
- IDLE: start=1 -> latch a, b, op, operand signs; convert to magnitudes for signed ops (|−2^31| = 0x80000000 as unsigned); clear iteration counter; go CALC.
- CALC: one iteration per cycle, counter 0..31; after the 32nd iteration go FIX.
  - Multiply: radix-2 shift-add on magnitudes into a 64-bit product register.
  - Divide: restoring division on magnitudes; 33-bit partial remainder, 32-bit quotient.
- FIX: apply sign correction and write HI/LO, assert done, go IDLE.
  - MULT: negate the 64-bit product if sign(a) XOR sign(b). HI = product[63:32], LO = product[31:0].
  - DIV: quotient negated if sign(a) XOR sign(b); remainder takes the sign of a. LO = quotient, HI = remainder. 32-bit wrap: 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0.
  - Divide by zero (DIV or DIVU): LO = 0xFFFFFFFF, HI = latched a. Latency is unchanged.
- Operands are latched at accept; later changes on a/b have no effect. HI/LO hold their old values until FIX.
- hi_we/lo_we are honoured only in IDLE with start=0. They are ignored while busy and ignored when start=1 in the same cycle (start wins). hi_we and lo_we together write a to both.

## Timing
- Reset (asynchronous, any state): state=IDLE, busy=0, done=0, hi=0, lo=0, counter and internal registers=0.
- Reset mid-operation: the operation is aborted and no HI/LO update occurs.
- Accept edge E0: busy=1 from E0.
- Edges E1..E32 perform the 32 iterations.
- Edge E33 (FIX): HI/LO updated, busy=0, done=1 for exactly one cycle. Result readable 33 cycles after the accept edge.
- Back-to-back: a start in the cycle where done=1 is accepted (busy=0 then).
- start with busy=1 is ignored; no queuing.
- MTHI/MTLO: HI/LO updated at the next rising edge; no busy, no done.

## Test plan
- Reset: pulse reset asynchronously mid-cycle -> hi=0, lo=0, busy=0, done=0 immediately; MTHI a=0x12345678 -> hi=0x12345678 next cycle, lo unchanged.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> busy high 33 cycles, then hi=0xFFFFFFFE, lo=0x00000001, single-cycle done. MULT a=0xFFFFFFFD (−3), b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. MULT a=b=0x80000000 -> hi=0x40000000, lo=0.
- DIV a=0xFFFFFFF9 (−7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=100, b=7 -> lo=14, hi=2. DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- Divide by zero: DIVU a=100, b=0 -> lo=0xFFFFFFFF, hi=0x00000064 after 33 cycles.
- Hazards: change a/b during CALC -> result unaffected; start and hi_we pulsed during busy -> ignored; start+lo_we together in IDLE -> operation runs, LO written only by the result.
- Reset at cycle 10 of a DIVU -> busy=0, hi/lo=0, no done pulse; a new MULTU 3×4 afterwards gives lo=12, hi=0.
